interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Sequences hardware-interrupt entry for the 5-stage 16-bit RISC pipeline.
//  Latches an interrupt request and waits for an instruction boundary. It then
//  freezes fetch, flushes IF/ID and lets in-flight instructions drain.
//  It borrows the data-memory port through a req/gnt handshake to push PC
//  (high word, then low word) and CCR onto the stack. It reads the 32-bit ISR
//  vector, redirects fetch, and masks further entry until RTI completes.
// PARAMETERS
//  DRAIN_CYCLES  3       cycles fetch stays frozen before the first push (ID/EX/MEM drain); 0 allowed
//  ADDR_W        12      data-memory address width
//  VEC_ADDR      12'h002 address of vector low word; high word at VEC_ADDR+1
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  interrupt      in   1       external request; rising edge of sampled level is an event
//  inst_boundary  in   1       1 = ID holds no half-consumed multi-word instruction (e.g. LDM)
//  rti_done       in   1       1-cycle pulse from WB when RTI retires; clears in_isr
//  pc_in          in   32      address of next instruction to execute (return address)
//  ccr_in         in   3       current condition flags {C,N,Z}
//  sp_in          in   ADDR_W  current stack pointer
//  sp_dec         out  1       1-cycle pulse: SP owner decrements SP at next edge
//  mem_req        out  1       request for the data-memory port
//  mem_gnt        in   1       port granted this cycle; write/read completes this cycle
//  mem_we         out  1       1 = write, 0 = read
//  mem_addr       out  ADDR_W  access address
//  mem_wdata      out  16      write data
//  mem_rdata      in   16      read data, valid in the gnt cycle (combinational read)
//  freeze_fetch   out  1       hold PC and IF/ID
//  flush_ifid     out  1       zero IF/ID (bubble)
//  pc_load        out  1       1-cycle pulse: PC <= pc_value
//  pc_value       out  32      ISR entry address
//  int_ack        out  1       1-cycle pulse, same cycle as pc_load
//  in_isr         out  1       1 while the handler runs; masks new entry
// BEHAVIOUR
//  Reset: state=IDLE; pending, in_isr, prev-sample, counter, ret_pc, ret_ccr and vec clear to 0.
//   All outputs are 0. Reset mid-sequence aborts immediately with no partial-push recovery.
//  Event detection: int_q <= interrupt each edge. (interrupt & ~int_q) sets pending.
//   Pending is 1-deep: an event while pending=1 is dropped. Pending clears on leaving IDLE.
//  States (Moore outputs), encoded 3-bit:
//   IDLE: pending & ~in_isr & inst_boundary -> DRAIN. On that transition it captures
//     ret_pc<=pc_in and ret_ccr<=ccr_in and loads cnt<=DRAIN_CYCLES.
//     If DRAIN_CYCLES=0, it goes directly to PUSH_PCH (flush_ifid still pulses 1 cycle).
//   DRAIN: freeze_fetch=1. flush_ifid=1 in the first DRAIN cycle only. cnt-- each cycle.
//     Exits to PUSH_PCH after exactly DRAIN_CYCLES cycles in DRAIN.
//   PUSH_PCH: req=1, we=1, addr=sp_in, wdata=ret_pc[31:16]. On gnt: sp_dec=1 -> PUSH_PCL.
//   PUSH_PCL: same handshake, wdata=ret_pc[15:0] -> PUSH_CCR.
//   PUSH_CCR: same handshake, wdata={13'b0,ret_ccr} -> VEC_L.
//   VEC_L: req=1, we=0, addr=VEC_ADDR. On gnt: vec[15:0]<=mem_rdata -> VEC_H.
//   VEC_H: addr=VEC_ADDR+1 (mod 2^ADDR_W). On gnt: vec[31:16]<=mem_rdata -> JUMP.
//   JUMP: pc_load=1, int_ack=1, pc_value=vec. in_isr<=1 at exit -> IDLE.
//  freeze_fetch=1 in DRAIN..JUMP inclusive. In IDLE it is 0 even if in_isr=1.
//  Handshake: without gnt the state holds. req/we/addr/wdata stay stable. No sp_dec, no timeout.
//   sp_dec pulses only in a gnt cycle of a PUSH state. At most one memory access per cycle.
//  sp_in is decremented externally after each sp_dec, so successive pushes use SP, SP-1, SP-2.
//   SP wrap below 0 is the SP owner's concern.
//  pc_value holds the last vector after JUMP. It is meaningful only while pc_load=1.
//  rti_done clears in_isr at the next edge. If rti_done and pending coincide, entry may start the
//   edge after in_isr clears. An event arriving during the ISR is held and taken after RTI.
//  An interrupt event in any non-IDLE state sets pending and does not disturb the current sequence.
//  Latency (gnt=1, DRAIN_CYCLES=3, boundary=1): interrupt rises in cycle 0 -> pending in cycle 1,
//   DRAIN in cycles 2-4, pushes in cycles 5-7, vector reads in cycles 8-9, pc_load in cycle 10.
// TESTING
//  T1 basic: pc_in=32'h0001_0040, ccr=3'b101, sp=12'hFFF, gnt=1, mem[2]=16'h0100, mem[3]=0.
//     Expect writes FFF<=0001, FFE<=0040, FFD<=0005; pc_load in cycle 10 with pc_value=32'h0000_0100.
//  T2 stall: drop gnt for 4 cycles during PUSH_PCL.
//     Expect req and wdata=0040 held, no sp_dec, pc_load 4 cycles later.
//  T3 masking: second rising edge during PUSH_CCR, third during ISR.
//     Expect one entry only, pending=1. After rti_done a second entry starts; the third edge is lost.
//  T4 boundary: inst_boundary=0 for 5 cycles with pending=1.
//     Expect IDLE held, freeze_fetch=0. Entry starts the cycle after boundary=1.
//  T5 reset mid-op: assert rst during VEC_L.
//     Expect all outputs 0 asynchronously, state IDLE, in_isr=0, pending=0.
//  T6 DRAIN_CYCLES=0: expect a 1-cycle flush_ifid with PUSH_PCH in the cycle after IDLE.

Source files
------------

// File: rtl/interrupt_sequencer_if.sv
// Data-memory port shared between the pipeline and the interrupt sequencer.
// The master drives a request and holds it until the arbiter grants the port.
interface interrupt_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;

  modport master (output req, we, addr, wdata, input gnt, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/interrupt_sequencer.sv
// Hardware-interrupt entry sequencer for the 5-stage 16-bit RISC pipeline:
// drain, push PC/CCR through the borrowed data port, fetch the vector, redirect.
module interrupt_sequencer #(
  parameter int                DRAIN_CYCLES = 3,
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] VEC_ADDR     = 'h002
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interrupt_i,
  input  logic                 inst_boundary_i,
  input  logic                 rti_done_i,
  input  logic [31:0]          pc_i,
  input  logic [2:0]           ccr_i,
  input  logic [ADDR_W-1:0]    sp_i,
  output logic                 sp_dec_o,
  interrupt_sequencer_if.master mem,
  output logic                 freeze_fetch_o,
  output logic                 flush_ifid_o,
  output logic                 pc_load_o,
  output logic [31:0]          pc_value_o,
  output logic                 int_ack_o,
  output logic                 in_isr_o
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, VEC_L, VEC_H, JUMP
  } state_e;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             in_isr_q, in_isr_d;
  logic             int_q;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ret_pc_q, ret_pc_d;
  logic [2:0]       ret_ccr_q, ret_ccr_d;
  logic [31:0]      vec_q, vec_d;

  // NOTE: every register here is a plain flop, so all of them take the async reset;
  // there is no storage array that would justify leaving state unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= IDLE;
      pending_q <= 1'b0;
      in_isr_q  <= 1'b0;
      int_q     <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      ret_pc_q  <= '0;
      ret_ccr_q <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      in_isr_q  <= in_isr_d;
      int_q     <= interrupt_i;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      ret_pc_q  <= ret_pc_d;
      ret_ccr_q <= ret_ccr_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d        = state_q;
    pending_d      = pending_q | (interrupt_i & ~int_q);
    in_isr_d       = in_isr_q & ~rti_done_i;
    first_d        = 1'b0;
    cnt_d          = cnt_q;
    ret_pc_d       = ret_pc_q;
    ret_ccr_d      = ret_ccr_q;
    vec_d          = vec_q;
    mem.req        = 1'b0;
    mem.we         = 1'b0;
    mem.addr       = '0;
    mem.wdata      = '0;
    sp_dec_o       = 1'b0;
    freeze_fetch_o = 1'b0;
    pc_load_o      = 1'b0;
    int_ack_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending_q && !in_isr_q && inst_boundary_i) begin
          pending_d = 1'b0;
          first_d   = 1'b1;
          ret_pc_d  = pc_i;
          ret_ccr_d = ccr_i;
          cnt_d     = CNT_W'(DRAIN_CYCLES);
          state_d   = (DRAIN_CYCLES == 0) ? PUSH_PCH : DRAIN;
        end
      end
      DRAIN: begin
        freeze_fetch_o = 1'b1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = PUSH_PCH;
      end
      PUSH_PCH, PUSH_PCL, PUSH_CCR: begin
        freeze_fetch_o = 1'b1;
        mem.req        = 1'b1;
        mem.we         = 1'b1;
        mem.addr       = sp_i;
        unique case (state_q)
          PUSH_PCH: mem.wdata = ret_pc_q[31:16];
          PUSH_PCL: mem.wdata = ret_pc_q[15:0];
          default:  mem.wdata = {13'b0, ret_ccr_q};
        endcase
        if (mem.gnt) begin
          sp_dec_o = 1'b1;
          unique case (state_q)
            PUSH_PCH: state_d = PUSH_PCL;
            PUSH_PCL: state_d = PUSH_CCR;
            default:  state_d = VEC_L;
          endcase
        end
      end
      VEC_L: begin
        freeze_fetch_o = 1'b1;
        mem.req        = 1'b1;
        mem.addr       = VEC_ADDR;
        if (mem.gnt) begin
          vec_d[15:0] = mem.rdata;
          state_d     = VEC_H;
        end
      end
      VEC_H: begin
        freeze_fetch_o = 1'b1;
        mem.req        = 1'b1;
        mem.addr       = VEC_ADDR + ADDR_W'(1);
        if (mem.gnt) begin
          vec_d[31:16] = mem.rdata;
          state_d      = JUMP;
        end
      end
      JUMP: begin
        freeze_fetch_o = 1'b1;
        pc_load_o      = 1'b1;
        int_ack_o      = 1'b1;
        // Entering the handler wins over a coincident rti_done.
        in_isr_d       = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_ifid_o = first_q;
  assign pc_value_o   = vec_q;
  assign in_isr_o     = in_isr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: pushes expected stack writes and ISR
// vectors to queues at stimulus time and pops them when the DUT performs them.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, interrupt, inst_boundary, rti_done, irq1, gnt_en;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic [15:0] vec_lo, vec_hi;
  logic [11:0] dec_cnt, sp;

  logic        sp_dec, freeze, flush, pc_load, int_ack, in_isr;
  logic [31:0] pc_value;
  logic        sp_dec1, freeze1, flush1, pc_load1, int_ack1, in_isr1;
  logic [31:0] pc_value1;

  interrupt_sequencer_if #(.ADDR_W(12)) bus ();
  interrupt_sequencer_if #(.ADDR_W(12)) bus1 ();

  assign sp        = 12'hFFF - dec_cnt;
  assign bus.gnt   = gnt_en;
  assign bus.rdata = (bus.addr == 12'h002) ? vec_lo : (bus.addr == 12'h003) ? vec_hi : 16'h0000;
  assign bus1.gnt   = 1'b1;
  assign bus1.rdata = (bus1.addr == 12'h002) ? 16'h0200 : 16'h0000;

  interrupt_sequencer #(.DRAIN_CYCLES(3), .ADDR_W(12), .VEC_ADDR(12'h002)) u_dut (
    .clk(clk), .rst(rst), .interrupt_i(interrupt), .inst_boundary_i(inst_boundary),
    .rti_done_i(rti_done), .pc_i(pc_in), .ccr_i(ccr_in), .sp_i(sp), .sp_dec_o(sp_dec),
    .mem(bus), .freeze_fetch_o(freeze), .flush_ifid_o(flush), .pc_load_o(pc_load),
    .pc_value_o(pc_value), .int_ack_o(int_ack), .in_isr_o(in_isr)
  );

  interrupt_sequencer #(.DRAIN_CYCLES(0), .ADDR_W(12), .VEC_ADDR(12'h002)) u_dut0 (
    .clk(clk), .rst(rst), .interrupt_i(irq1), .inst_boundary_i(inst_boundary),
    .rti_done_i(rti_done), .pc_i(pc_in), .ccr_i(ccr_in), .sp_i(12'hFFF), .sp_dec_o(sp_dec1),
    .mem(bus1), .freeze_fetch_o(freeze1), .flush_ifid_o(flush1), .pc_load_o(pc_load1),
    .pc_value_o(pc_value1), .int_ack_o(int_ack1), .in_isr_o(in_isr1)
  );

  // Stack pointer owner: decrements once per granted push.
  always @(posedge clk or posedge rst) begin
    if (rst) dec_cnt <= 12'd0;
    else if (sp_dec) dec_cnt <= dec_cnt + 12'd1;
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] pc_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every granted write and every pc_load pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req && bus.we && gnt_en) begin
        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          wr_t e;
          e = wr_q.pop_front();
          check("push_addr", 64'(bus.addr), 64'(e.addr));
          check("push_data", 64'(bus.wdata), 64'(e.data));
          check("sp_dec_on_gnt", 64'(sp_dec), 64'd1);
        end
      end else if (bus.req) begin
        check("no_sp_dec", 64'(sp_dec), 64'd0);
      end
      if (pc_load) begin
        check("pc_load_expected", 64'(pc_q.size() != 0), 64'd1);
        if (pc_q.size() != 0) begin
          logic [31:0] v;
          v = pc_q.pop_front();
          check("pc_value", 64'(pc_value), 64'(v));
          check("int_ack", 64'(int_ack), 64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_writes();
    wr_q.push_back('{addr: sp,          data: pc_in[31:16]});
    wr_q.push_back('{addr: sp - 12'd1,  data: pc_in[15:0]});
    wr_q.push_back('{addr: sp - 12'd2,  data: {13'b0, ccr_in}});
  endtask

  task automatic wait_pc_load(input string tag, input int max);
    int n;
    n = 0;
    while (!pc_load && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(pc_load), 64'd1);
  endtask

  task automatic rti();
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    check("in_isr_cleared", 64'(in_isr), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; interrupt = 1'b0; inst_boundary = 1'b1; rti_done = 1'b0; irq1 = 1'b0;
    gnt_en = 1'b1; pc_in = 32'h0001_0040; ccr_in = 3'b101;
    vec_lo = 16'h0100; vec_hi = 16'h0000;
    tick_n(2);
    check("reset_bus", 64'({bus.req, bus.we, bus.addr, bus.wdata}), 64'd0);
    check("reset_ctl", 64'({sp_dec, freeze, flush, pc_load, pc_value, int_ack, in_isr}), 64'd0);
    rst = 1'b0;
    tick();

    // T1 basic entry with latency points
    interrupt = 1'b1;
    expect_writes();
    pc_q.push_back(32'h0000_0100);
    tick();
    check("t1_pending", 64'(u_dut.pending_q), 64'd1);
    check("t1_idle_nofreeze", 64'(freeze), 64'd0);
    tick();
    interrupt = 1'b0;
    check("t1_drain_freeze", 64'(freeze), 64'd1);
    check("t1_flush_first", 64'(flush), 64'd1);
    tick();
    check("t1_flush_once", 64'(flush), 64'd0);
    tick_n(2);
    check("t1_pch_req", 64'({bus.req, bus.we, bus.addr}), 64'({1'b1, 1'b1, 12'hFFF}));
    tick_n(4);
    check("t1_no_early_load", 64'(pc_load), 64'd0);
    tick();
    check("t1_pc_load_c10", 64'(pc_load), 64'd1);
    tick();
    check("t1_in_isr", 64'({in_isr, freeze, pc_load}), 64'({1'b1, 1'b0, 1'b0}));
    rti();

    // T2 grant stall during PUSH_PCL
    vec_hi = 16'h0001; vec_lo = 16'h2000;
    interrupt = 1'b1;
    expect_writes();
    pc_q.push_back(32'h0001_2000);
    tick_n(2);
    interrupt = 1'b0;
    tick_n(4);
    gnt_en = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_req", 64'({bus.req, bus.we, bus.addr}), 64'({1'b1, 1'b1, 12'hFFB}));
      check("t2_hold_wdata", 64'(bus.wdata), 64'h0040);
      check("t2_no_sp_dec", 64'(sp_dec), 64'd0);
      tick();
    end
    gnt_en = 1'b1;
    tick_n(3);
    check("t2_no_early_load", 64'(pc_load), 64'd0);
    tick();
    check("t2_pc_load_late", 64'(pc_load), 64'd1);
    tick();
    rti();

    // T3 masking: second edge during PUSH_CCR, third during the ISR
    interrupt = 1'b1;
    expect_writes();
    pc_q.push_back(32'h0001_2000);
    tick_n(2);
    interrupt = 1'b0;
    tick_n(5);
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    check("t3_pending_set", 64'(u_dut.pending_q), 64'd1);
    tick_n(3);
    check("t3_isr_masked", 64'({in_isr, u_dut.pending_q, freeze}), 64'({1'b1, 1'b1, 1'b0}));
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    tick_n(3);
    check("t3_no_entry_in_isr", 64'({freeze, u_dut.pending_q}), 64'({1'b0, 1'b1}));
    pc_in = 32'hABCD_1234; ccr_in = 3'b010;
    expect_writes();
    pc_q.push_back(32'h0001_2000);
    rti();
    tick();
    check("t3_second_entry", 64'(freeze), 64'd1);
    wait_pc_load("t3_second_load", 20);
    tick();
    rti();
    tick_n(10);
    check("t3_third_lost", 64'({freeze, u_dut.pending_q}), 64'd0);

    // T4 instruction boundary hold-off
    pc_in = 32'h0002_0008; ccr_in = 3'b011;
    inst_boundary = 1'b0;
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_idle_held", 64'({u_dut.pending_q, freeze}), 64'({1'b1, 1'b0}));
      tick();
    end
    inst_boundary = 1'b1;
    expect_writes();
    pc_q.push_back(32'h0001_2000);
    tick();
    check("t4_entry_starts", 64'({freeze, flush}), 64'({1'b1, 1'b1}));
    wait_pc_load("t4_pc_load", 20);
    tick();
    rti();

    // T5 reset during VEC_L
    interrupt = 1'b1;
    expect_writes();
    tick_n(2);
    interrupt = 1'b0;
    tick_n(6);
    check("t5_in_vec_l", 64'({bus.req, bus.we, bus.addr}), 64'({1'b1, 1'b0, 12'h002}));
    rst = 1'b1;
    #1;
    check("t5_bus_zero", 64'({bus.req, bus.we, bus.addr, bus.wdata}), 64'd0);
    check("t5_ctl_zero", 64'({sp_dec, freeze, flush, pc_load, pc_value, int_ack, in_isr}), 64'd0);
    check("t5_state_idle", 64'({u_dut.state_q, u_dut.pending_q}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // T6 zero drain cycles: flush coincides with the first PUSH_PCH cycle
    irq1 = 1'b1;
    tick();
    check("t6_idle", 64'(freeze1), 64'd0);
    tick();
    irq1 = 1'b0;
    check("t6_pch_now", 64'({bus1.req, bus1.we, freeze1, flush1, sp_dec1}), 64'h1F);
    check("t6_pch_data", 64'(bus1.wdata), 64'h0002);
    tick();
    check("t6_flush_once", 64'({flush1, bus1.req}), 64'({1'b0, 1'b1}));
    tick_n(4);
    check("t6_pc_load", 64'({pc_load1, int_ack1, pc_value1}), 64'({1'b1, 1'b1, 32'h0000_0200}));
    tick();
    check("t6_in_isr", 64'(in_isr1), 64'd1);

    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("pc_q_drained", 64'(pc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
